// File: rtl/dram_fill_engine.sv
// AXI4 write-only fill master: one full-line INCR burst per line, bounded outstanding bursts.
// Optional DRAM_FILL_PATTERN_EN: each beat carries its own byte address instead of zeros.
module dram_fill_engine #(
    parameter int unsigned ADDR_BITS       = 32,
    parameter int unsigned DATA_BITS       = 64,
    parameter int unsigned LINE_SIZE       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_BITS        = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic [CNT_BITS-1:0]    num_lines,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   axi_aw_valid,
    input  logic                   axi_aw_ready,
    output logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
    output logic [7:0]             axi_aw_bits_len,
    output logic [2:0]             axi_aw_bits_size,
    output logic                   axi_w_valid,
    input  logic                   axi_w_ready,
    output logic [DATA_BITS-1:0]   axi_w_bits_data,
    output logic [DATA_BITS/8-1:0] axi_w_bits_strb,
    output logic                   axi_w_bits_last,
    output logic                   axi_b_ready,
    input  logic                   axi_b_valid,
    input  logic [1:0]             axi_b_bits_resp
);
    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int unsigned BEATS      = LINE_SIZE * 8 / DATA_BITS;
    localparam int unsigned SIZE_LOG   = $clog2(BEAT_BYTES);
    localparam int unsigned LINE_SHIFT = $clog2(LINE_SIZE);
    localparam int unsigned BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OUT_BITS   = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [CNT_BITS-1:0]    num_q, num_d;
    logic [CNT_BITS-1:0]    aw_cnt_q, aw_cnt_d;
    logic [CNT_BITS-1:0]    w_cnt_q, w_cnt_d;
    logic [CNT_BITS-1:0]    b_cnt_q, b_cnt_d;
    logic [BEAT_BITS-1:0]   beat_q, beat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   aw_valid_q, aw_valid_d;
    logic [ADDR_BITS-1:0]   aw_addr_q, aw_addr_d;
    logic                   w_valid_q, w_valid_d;
    logic [DATA_BITS-1:0]   w_data_q, w_data_d;
    logic                   w_last_q, w_last_d;
    logic                   b_ready_q, b_ready_d;

    logic                   aw_fire, w_fire, b_fire;
    logic [OUT_BITS-1:0]    outstanding;
`ifdef DRAM_FILL_PATTERN_EN
    logic [ADDR_BITS-1:0]   beat_addr;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        aw_cnt_d    = aw_cnt_q;
        w_cnt_d     = w_cnt_q;
        b_cnt_d     = b_cnt_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        aw_valid_d  = aw_valid_q;
        aw_addr_d   = aw_addr_q;
        w_valid_d   = w_valid_q;
        w_data_d    = w_data_q;
        w_last_d    = w_last_q;
        b_ready_d   = b_ready_q;
        outstanding = '0;
`ifdef DRAM_FILL_PATTERN_EN
        beat_addr   = '0;
`endif
        aw_fire = aw_valid_q & axi_aw_ready;
        w_fire  = w_valid_q & axi_w_ready;
        // A response with nothing outstanding cannot belong to this fill; drop it.
        b_fire  = b_ready_q & axi_b_valid & (b_cnt_q != aw_cnt_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d   = base_addr & ~ADDR_BITS'(LINE_SIZE - 1);
                    num_d    = num_lines;
                    aw_cnt_d = '0;
                    w_cnt_d  = '0;
                    b_cnt_d  = '0;
                    beat_d   = '0;
                    err_d    = 1'b0;
                    if (num_lines == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = StRun;
                        busy_d     = 1'b1;
                        b_ready_d  = 1'b1;
                        aw_valid_d = 1'b1;
                        aw_addr_d  = base_d;
                    end
                end
            end
            StRun, StDrain: begin
                aw_cnt_d = aw_cnt_q + CNT_BITS'(aw_fire);
                w_cnt_d  = w_cnt_q + CNT_BITS'(w_fire & w_last_q);
                b_cnt_d  = b_cnt_q + CNT_BITS'(b_fire);
                if (b_fire && axi_b_bits_resp != 2'b00) begin
                    err_d = 1'b1;
                end
                if (w_fire) begin
                    beat_d = w_last_q ? '0 : beat_q + BEAT_BITS'(1);
                end

                // Exact in OUT_BITS since the true difference never exceeds MAX_OUTSTANDING.
                outstanding = OUT_BITS'(aw_cnt_d - b_cnt_d);
                if (!(aw_valid_q && !axi_aw_ready)) begin
                    aw_valid_d = (aw_cnt_d < num_q) && (outstanding < OUT_BITS'(MAX_OUTSTANDING));
                    if (aw_valid_d) begin
                        aw_addr_d = base_q + (ADDR_BITS'(aw_cnt_d) << LINE_SHIFT);
                    end
                end

                if (!(w_valid_q && !axi_w_ready)) begin
                    w_valid_d = w_cnt_d < aw_cnt_d;
                    w_last_d  = w_valid_d && (beat_d == BEAT_BITS'(BEATS - 1));
                    if (w_valid_d) begin
`ifdef DRAM_FILL_PATTERN_EN
                        beat_addr = base_q + (ADDR_BITS'(w_cnt_d) << LINE_SHIFT)
                                  + (ADDR_BITS'(beat_d) << SIZE_LOG);
                        w_data_d  = DATA_BITS'(beat_addr);
`else
                        w_data_d  = '0;
`endif
                    end
                end

                if (aw_cnt_d == num_q && w_cnt_d == num_q) begin
                    if (b_cnt_d == num_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        b_ready_d = 1'b0;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            num_q      <= '0;
            aw_cnt_q   <= '0;
            w_cnt_q    <= '0;
            b_cnt_q    <= '0;
            beat_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_last_q   <= 1'b0;
            b_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            aw_cnt_q   <= aw_cnt_d;
            w_cnt_q    <= w_cnt_d;
            b_cnt_q    <= b_cnt_d;
            beat_q     <= beat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_last_q   <= w_last_d;
            b_ready_q  <= b_ready_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign axi_aw_valid     = aw_valid_q;
    assign axi_aw_bits_addr = aw_addr_q;
    assign axi_aw_bits_len  = 8'(BEATS - 1);
    assign axi_aw_bits_size = 3'(SIZE_LOG);
    assign axi_w_valid      = w_valid_q;
    assign axi_w_bits_data  = w_data_q;
    assign axi_w_bits_strb  = '1;
    assign axi_w_bits_last  = w_last_q;
    assign axi_b_ready      = b_ready_q;

endmodule

// File: doc/dram_fill_engine.md
# dram_fill_engine

AXI4 write-only master that initialises a line-aligned region of simulated DRAM before the core is released from its boot hold. It issues one full-line INCR burst per line over AW/W/B, keeps a bounded number of bursts outstanding, and reports completion and any error response. It sits in front of the DRAM model's AW/W/B channels, muxed with the core's write path by the harness; AR/R are not used.

## Interface
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 64, W data width (power of two, 8..512)
- LINE_SIZE, 64, bytes per burst; LINE_SIZE*8/DATA_BITS beats per burst, 1..256
- MAX_OUTSTANDING, 4, max AW-issued bursts without B response (1..15)
- CNT_BITS, 24, width of num_lines
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin fill (ignored while busy)
- base_addr  in  ADDR_BITS  region start; low log2(LINE_SIZE) bits ignored (forced 0)
- num_lines  in  CNT_BITS  lines to fill; sampled with start
- busy  out  1  fill in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: some B response was non-OKAY
- axi_aw_valid  out  1  write address valid
- axi_aw_ready  in  1  write address ready
- axi_aw_bits_addr  out  ADDR_BITS  burst start address
- axi_aw_bits_len  out  8  beats-1
- axi_aw_bits_size  out  3  log2(DATA_BITS/8), constant
- axi_w_valid  out  1  write data valid
- axi_w_ready  in  1  write data ready
- axi_w_bits_data  out  DATA_BITS  fill data
- axi_w_bits_strb  out  DATA_BITS/8  always all ones
- axi_w_bits_last  out  1  final beat of burst
- axi_b_ready  out  1  high whenever busy
- axi_b_valid  in  1  write response valid
- axi_b_bits_resp  in  2  write response code
- Burst type INCR, ID 0, lock/cache/prot/qos 0 are tied off by the integrator.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches base, num_lines; clears err, counters aw_cnt, w_cnt (bursts fully sent), b_cnt. num_lines=0 -> DONE, else RUN.
- RUN: AW and W advance independently. AW issues burst aw_cnt at base+aw_cnt*LINE_SIZE (mod 2^ADDR_BITS) when aw_cnt<num_lines and aw_cnt-b_cnt<MAX_OUTSTANDING. W sends beats only for bursts with w_cnt<aw_cnt (data never precedes its AW handshake); beat counter wraps at beats-1 with w_last, incrementing w_cnt. When aw_cnt=w_cnt=num_lines -> DRAIN.
- DRAIN: wait until b_cnt=num_lines -> DONE. B counted in RUN and DRAIN.
- DONE: done=1, busy=0 for one cycle -> IDLE.
- Any B handshake with resp!=0 sets err; err holds until next accepted start.
- Counters are CNT_BITS wide; outstanding count fits log2(MAX_OUTSTANDING)+1 bits.
- Reset mid-fill: all state, counters, outputs cleared immediately; in-flight bursts abandoned (harness resets the DRAM model with it).

## Timing
- Reset values: busy, done, err, axi_aw_valid, axi_w_valid, axi_w_bits_last, axi_b_ready = 0; address/data outputs 0.
- All outputs registered. start at edge N -> busy, axi_b_ready, axi_aw_valid high from cycle N+1.
- Valid held with payload stable until ready; no valid withdrawn.
- Back-to-back: one AW per cycle, one W beat per cycle, given ready.
- First W valid the cycle after its AW handshake.
- Final B handshake at edge M -> done=1, busy=0 during cycle M+1.
- num_lines=0: done during cycle N+1, no AW/W activity.

## Configuration
- DRAM_FILL_PATTERN_EN defined: beat data = byte address of that beat, zero-extended/truncated to DATA_BITS (verifiable pattern).
- Undefined: all beats zero. Handshakes and timing identical either way.

## Test plan
- base 0x1000, num_lines 2, all ready/b_valid high -> AW 0x1000 then 0x1040, len 7, size 3; 16 W beats, last on beats 8 and 16; done once; err 0.
- num_lines 0 -> done pulse cycle after start, axi_aw_valid never asserted.
- num_lines 8, b_valid held low -> exactly 4 AW handshakes, axi_aw_valid stays 0 until a B arrives, then one more AW.
- w_ready toggled every other cycle -> data/last stable while stalled, 8 beats per burst, no beats before matching AW.
- resp 2'b10 on burst 1 of 3 -> err 1 at done, remains 1 in IDLE, cleared by next start.
- DRAM_FILL_PATTERN_EN, base 0x1000 -> beat 3 of second burst carries 0x1058; reset during RUN -> all outputs 0 asynchronously, subsequent start fills normally.
